// File: rtl/gsim_arbiter.sv
// gsim_arbiter: round-robin front-end that sequences one GSIM solver core
// through load / solve / drain for N requesters and tags results by owner.
module gsim_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  input  logic [16*N-1:0]   req_b,
  output logic [N-1:0]      req_ready,
  output logic              core_in_en,
  output logic [15:0]       core_b_in,
  input  logic              core_out_valid,
  input  logic [31:0]       core_x_out,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [3:0]        res_idx,
  output logic [31:0]       res_data,
  output logic              res_last,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic [15:0]       last_latency,
  output logic              protocol_err
);

  localparam int unsigned BW = 16;
  localparam int unsigned XW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [IDW-1:0]   r_grant_id;
  logic [CW-1:0]    r_beat_cnt;
  logic [LW-1:0]    r_lat_cnt;
  logic [LW-1:0]    r_last_latency;
  logic [CW-1:0]    r_res_cnt;
  logic             r_ov_d1;
  logic             r_res_valid;
  logic [IDW-1:0]   r_res_id;
  logic [CW-1:0]    r_res_idx;
  logic [XW-1:0]    r_res_data;
  logic             r_res_last;
  logic             r_protocol_err;

  logic [BW-1:0]    w_slice [N];
  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_next_grant;
  logic             w_found;
  logic             w_accept;
  logic             w_load_done;
  logic             w_capture;
  logic             w_grant;

  // Split the flat b bus into per-requester words
  for (genvar gi = 0; gi < N; gi++) begin : g_slice
    assign w_slice[gi] = req_b[gi*BW +: BW];
  end

  // Round-robin search starting one past the last grant, with wrap
  always_comb begin
    w_found      = 1'b0;
    w_next_grant = r_grant_id;
    w_cand       = r_grant_id;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = (w_cand == IDW'(N-1)) ? '0 : w_cand + IDW'(1);
      if (!w_found && req_valid[w_cand]) begin
        w_found      = 1'b1;
        w_next_grant = w_cand;
      end
    end
  end

  // Phase sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and combinational load-side handshake
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    core_in_en  = 1'b0;
    core_b_in   = '0;
    w_accept    = 1'b0;
    w_load_done = 1'b0;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        req_ready[r_grant_id] = 1'b1;
        core_in_en  = req_valid[r_grant_id];
        core_b_in   = w_slice[r_grant_id];
        w_accept    = req_valid[r_grant_id];
        w_load_done = w_accept && (r_beat_cnt == CW'(15));
        if (w_load_done) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_capture = r_ov_d1;
        if (core_out_valid) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_capture = r_ov_d1;
        if (r_ov_d1 && (r_res_cnt == CW'(15))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant register and load beat counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_id <= IDW'(N-1);
      r_beat_cnt <= '0;
    end else if (w_grant) begin
      r_grant_id <= w_next_grant;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  // Saturating solve-latency counter and its snapshot at first core output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lat_cnt      <= '0;
      r_last_latency <= '0;
    end else begin
      if (w_load_done) begin
        r_lat_cnt <= '0;
      end else if ((r_state == S_WAIT) && (r_lat_cnt != '1)) begin
        r_lat_cnt <= r_lat_cnt + LW'(1);
      end
      if ((r_state == S_WAIT) && core_out_valid) r_last_latency <= r_lat_cnt;
    end
  end

  // Delayed core valid; outputs seen outside WAIT/DRAIN are dropped here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ov_d1 <= 1'b0;
    else       r_ov_d1 <= core_out_valid && ((r_state == S_WAIT) || (r_state == S_DRAIN));
  end

  // Result beat capture and element index tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_res_last  <= 1'b0;
      r_res_cnt   <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_id    <= r_grant_id;
      r_res_idx   <= r_res_cnt;
      r_res_data  <= core_x_out;
      r_res_last  <= (r_res_cnt == CW'(15));
      r_res_cnt   <= r_res_cnt + CW'(1);
    end else begin
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      if (w_grant) r_res_cnt <= '0;
    end
  end

  // Sticky flag for core output arriving while no job is solving
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_protocol_err <= 1'b0;
    end else if (core_out_valid && ((r_state == S_IDLE) || (r_state == S_LOAD))) begin
      r_protocol_err <= 1'b1;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign grant_id     = r_grant_id;
  assign last_latency = r_last_latency;
  assign protocol_err = r_protocol_err;
  assign res_valid    = r_res_valid;
  assign res_id       = r_res_id;
  assign res_idx      = r_res_idx;
  assign res_data     = r_res_data;
  assign res_last     = r_res_last;

endmodule

// File: doc/gsim_arbiter.md
# gsim_arbiter

Round-robin front-end that shares one GSIM Gauss-Seidel solver core among N requesters. Each job is one requester's 16-word b vector, and jobs run one at a time. The block sequences the core's three phases (load 16 b words, wait for the solve, drain 16 results) and routes the results back tagged with requester ID and element index. It sits between the requester ports and the single core instance; the core shares `clk` and `reset` with this block.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDW`, default 2: requester ID width, equal to clog2(N) and at least 1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N  requester i has a b word on its slice.
- `req_b`  in  16*N  signed b word; requester i uses bits [16i+15:16i].
- `req_ready`  out  N  one-hot or zero; the word is accepted when `req_valid[i] & req_ready[i]`.
- `core_in_en`  out  1  drives the core's `in_en`.
- `core_b_in`  out  16  drives the core's `b_in`.
- `core_out_valid`  in  1  the core's `out_valid`.
- `core_x_out`  in  32  the core's `x_out`; valid the cycle after each `core_out_valid` cycle.
- `res_valid`  out  1  result beat; there is no backpressure.
- `res_id`  out  IDW  requester that owns the result.
- `res_idx`  out  4  element index 0..15.
- `res_data`  out  32  x value, Q16.16 signed.
- `res_last`  out  1  high with index 15.
- `busy`  out  1  state is not IDLE.
- `grant_id`  out  IDW  current or last granted requester.
- `last_latency`  out  16  WAIT-state cycle count of the last completed job, saturating at 0xFFFF.
- `protocol_err`  out  1  sticky; set when `core_out_valid` is seen in IDLE or LOAD.

## Operation
- States: IDLE, LOAD, WAIT, DRAIN.
- IDLE:
  - If any `req_valid` is high, grant the first set bit searching upward from `(grant_id+1) mod N` with wrap.
  - Register the grant into `grant_id`, clear `beat_cnt` and go to LOAD.
  - `req_ready` is all zero in IDLE.
- LOAD:
  - `req_ready[grant_id]=1`, combinational.
  - `core_in_en = req_valid[grant_id]`.
  - `core_b_in` is the granted slice; in every other state `core_b_in` is 0.
  - Each accepted beat increments `beat_cnt` (4 bits).
  - The beat with `beat_cnt==15` moves to WAIT and clears `lat_cnt`.
  - The requester may stall by deasserting valid; the core tolerates gaps.
- WAIT:
  - `lat_cnt` increments each cycle, saturating.
  - On `core_out_valid`, go to DRAIN and load `last_latency <= lat_cnt`.
- DRAIN:
  - Result capture runs from the one-cycle delay `ov_d1 <= core_out_valid`.
  - When `ov_d1` is high: `res_valid<=1`, `res_data<=core_x_out`, `res_idx<=res_cnt`, `res_id<=grant_id`, `res_last<=(res_cnt==15)`, and `res_cnt++`.
  - Otherwise `res_valid<=0` and `res_last<=0`.
  - Capturing `res_cnt==15` returns the state to IDLE.
- `ov_d1`-driven capture also runs in WAIT; the first capture can only happen in DRAIN.
- `core_out_valid` in IDLE or LOAD sets `protocol_err`, and the result is dropped. `protocol_err` clears only on reset.
- Requester i's `req_valid` has no effect unless it is granted and the state is LOAD.

## Timing
- Reset values:
  - State IDLE; `req_ready=0`, `core_in_en=0`, `core_b_in=0`.
  - `res_valid=0`, `res_id=0`, `res_idx=0`, `res_data=0`, `res_last=0`.
  - `busy=0`, `grant_id=N-1`, so requester 0 wins first.
  - `last_latency=0`, `protocol_err=0`, all counters 0, `ov_d1=0`.
- Arbitration latency:
  - `req_valid` high in IDLE at cycle t gives `req_ready` high in cycle t+1.
  - The first beat is accepted no earlier than t+1.
  - Minimum LOAD length is 16 cycles.
- Result latency: `core_out_valid` high in cycle k gives `res_valid` high in cycle k+2. The 16 contiguous `core_out_valid` cycles produce 16 contiguous `res_valid` cycles.
- Back-to-back jobs: the cycle after the `res_last` beat is registered, the state is IDLE, so the next grant is visible one cycle later. The core is then in RECEIVE.
- Reset mid-job: the block and the core return to idle; no partial results are emitted after reset deasserts.

## Test plan
- Single job: requester 0 sends b=0x0001..0x0010 with valid continuously high -> 16 `core_in_en` beats in 16 cycles; later 16 `res_valid` beats with `res_id=0`, `res_idx` 0..15, `res_last` only at idx 15; `res_data` equals the core's x values; `last_latency` equals the WAIT length.
- Round robin, N=4: all four `req_valid` held high for 5 jobs -> grant order 0,1,2,3,0; `req_ready` never high for two requesters at once.
- Stalled load: requester 2 toggles valid 1,0,0,1,... -> `core_in_en` follows valid exactly; 16 accepted words; no beat lost or duplicated.
- Spurious core output: force `core_out_valid=1` for one cycle in IDLE -> `protocol_err=1` and stays set; no `res_valid`; the next job completes normally.
- Reset at beat 7 of LOAD, then requester 1 starts a fresh job -> all outputs take their reset values during reset; the new job returns exactly 16 results with `res_id=1`.
- Latency saturation: hold `core_out_valid` low for 70000 WAIT cycles -> `last_latency=0xFFFF` after DRAIN begins.
